// File: rtl/mem_pkg.sv
// Shared types for the data-memory access stage: funct3 codes, FSM states,
// byte-enable helpers and the MEM/WB bundle.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int BE_W = 4;
  typedef logic [BE_W-1:0] be_t;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_reg;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
  } wb_t;

  // Undefined encodings fall through to word size.
  function automatic size_t acc_size(input logic [2:0] f3);
    acc_size = SZ_W;
    unique case (1'b1)
      f3[1:0] == 2'b00: acc_size = SZ_B;
      f3[1:0] == 2'b01: acc_size = SZ_H;
      default: ;
    endcase
  endfunction

  function automatic be_t be_mask(input logic [2:0] f3,
                                  input logic [1:0] lo);
    be_mask = 4'b1111;
    unique case (acc_size(f3))
      SZ_B: be_mask = be_t'(1) << lo;
      SZ_H: be_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] st_lanes(input logic [2:0] f3,
                                           input logic [31:0] d);
    st_lanes = d;
    unique case (acc_size(f3))
      SZ_B: st_lanes = {4{d[7:0]}};
      SZ_H: st_lanes = {2{d[15:0]}};
      default: ;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [1:0] lo);
    misaligned = 1'b0;
    unique case (acc_size(f3))
      SZ_H: misaligned = lo[0];
      SZ_W: misaligned = |lo;
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/load_formatter.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (acc_size(funct3))
      SZ_B: data = funct3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H: data = funct3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores on the dm bus and fills MEM/WB.
// Optional MISALIGN_EXC_EN traps misaligned half/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int RD_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     alu_result,
  input  logic [31:0]     rs2_data,
  input  logic [RD_W-1:0] rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_reg,
  input  logic [2:0]      funct3,
  output logic            stall,
  mem_access_unit_if.master dm,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic            wb_mem_reg,
  output logic [31:0]     wb_mem_data,
  output logic [31:0]     wb_alu_result,
  output logic [RD_W-1:0] wb_rd,
  output logic            bus_err,
  output logic            misalign_exc
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  be_t               be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, alu_q, alu_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic [RD_W-1:0]   rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic              rw_q, rw_d, mreg_q, mreg_d;
  wb_t               wb_q, wb_d;
  logic              bus_err_q, bus_err_d, mis_q, mis_d;

  logic        is_mem, mis_hit, issue, timeout;
  logic [31:0] ld_data;

  load_formatter u_fmt (
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .rdata   (dm.dm_rdata),
    .data    (ld_data)
  );

  assign is_mem = mem_read | mem_write;
`ifdef MISALIGN_EXC_EN
  assign mis_hit = in_valid & is_mem & misaligned(funct3, alu_result[1:0]);
`else
  assign mis_hit = 1'b0;
`endif
  assign issue   = (state_q == IDLE) & in_valid & is_mem & ~mis_hit;
  assign timeout = (state_q == WAIT) & ~dm.dm_ack & (MAX_WAIT != 0)
                 & (32'(cnt_q) == MAX_WAIT - 1);
  // Stall drops in the completing cycle so EX/MEM advances at that edge.
  assign stall = ~rst & (issue | ((state_q == WAIT) & ~dm.dm_ack & ~timeout));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    mreg_d    = mreg_q;
    alu_d     = alu_q;
    wb_d      = wb_q;
    wb_d.valid = 1'b0;
    wb_rd_d   = wb_rd_q;
    bus_err_d = 1'b0;
    mis_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_write;
          be_d    = be_mask(funct3, alu_result[1:0]);
          addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
          wdata_d = st_lanes(funct3, rs2_data);
          f3_d    = funct3;
          lo_d    = alu_result[1:0];
          rd_d    = rd;
          rw_d    = reg_write & ~mem_write;
          mreg_d  = mem_reg;
          alu_d   = alu_result;
        end else if (in_valid) begin
          wb_d.valid      = 1'b1;
          wb_d.reg_write  = reg_write & ~mem_write & ~mis_hit;
          wb_d.mem_reg    = mem_reg;
          wb_d.mem_data   = '0;
          wb_d.alu_result = alu_result;
          wb_rd_d         = rd;
          mis_d           = mis_hit;
        end
      end
      WAIT: begin
        if (dm.dm_ack | timeout) begin
          state_d         = IDLE;
          req_d           = 1'b0;
          we_d            = 1'b0;
          be_d            = '0;
          wb_d.valid      = 1'b1;
          wb_d.reg_write  = rw_q & dm.dm_ack;
          wb_d.mem_reg    = mreg_q;
          wb_d.mem_data   = (dm.dm_ack & ~we_q) ? ld_data : '0;
          wb_d.alu_result = alu_q;
          wb_rd_d         = rd_q;
          bus_err_d       = timeout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      mreg_q    <= 1'b0;
      alu_q     <= '0;
      wb_q      <= '0;
      wb_rd_q   <= '0;
      bus_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      mreg_q    <= mreg_d;
      alu_q     <= alu_d;
      wb_q      <= wb_d;
      wb_rd_q   <= wb_rd_d;
      bus_err_q <= bus_err_d;
      mis_q     <= mis_d;
    end
  end

  assign dm.dm_req     = req_q;
  assign dm.dm_we      = we_q;
  assign dm.dm_addr    = addr_q;
  assign dm.dm_be      = be_q;
  assign dm.dm_wdata   = wdata_q;
  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_reg    = wb_q.mem_reg;
  assign wb_mem_data   = wb_q.mem_data;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_rd         = wb_rd_q;
  assign bus_err       = bus_err_q;
  assign misalign_exc  = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a
// lane/extension reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_result, rs2_data;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, mem_reg;
  logic [2:0]  funct3;
  logic        stall;
  logic        wb_valid, wb_reg_write, wb_mem_reg;
  logic [31:0] wb_mem_data, wb_alu_result;
  logic [4:0]  wb_rd;
  logic        bus_err, misalign_exc;

  int total = 0;
  int bad   = 0;

  mem_access_unit_if #(.ADDR_W(32)) dm_if ();

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(15), .RD_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .alu_result    (alu_result),
    .rs2_data      (rs2_data),
    .rd            (rd),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_reg       (mem_reg),
    .funct3        (funct3),
    .stall         (stall),
    .dm            (dm_if.master),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_reg    (wb_mem_reg),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_result (wb_alu_result),
    .wb_rd         (wb_rd),
    .bus_err       (bus_err),
    .misalign_exc  (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [2:0] f3,
                                        input logic [31:0] a);
    int off;
    off = int'(a % 4);
    case (f3 % 4)
      0: return 4'(1 << off);
      1: return (off >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3,
                                            input logic [31:0] d);
    case (f3 % 4)
      0: return (d & 32'hFF) * 32'h0101_0101;
      1: return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    logic        unsgn;
    unsgn = (f3 >= 4);
    case (f3 % 4)
      0: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (!unsgn && v >= 128) v = v - 256;
      end
      1: begin
        v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (!unsgn && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_reg   = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic xact(input bit ld, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rdt, input int dly,
                      input logic [4:0] rdi);
    int ns;
    in_valid   = 1'b1;
    alu_result = a;
    rs2_data   = wd;
    rd         = rdi;
    reg_write  = 1'b1;
    mem_read   = ld;
    mem_write  = !ld;
    mem_reg    = ld;
    funct3     = f3;
    dm_if.dm_ack = 1'b0;
    #1;
    ns = stall ? 1 : 0;
    @(posedge clk); #1;
    chk("req", dm_if.dm_req, 1);
    chk("we", dm_if.dm_we, !ld);
    chk("be", dm_if.dm_be, exp_be(f3, a));
    chk("addr", dm_if.dm_addr, a & 32'hFFFF_FFFC);
    if (!ld) chk("wdata", dm_if.dm_wdata, exp_wdata(f3, wd));
    for (int k = 0; k < dly; k++) begin
      if (stall) ns++;
      chk("wbv_wait", wb_valid, 0);
      @(posedge clk); #1;
    end
    chk("be_hold", dm_if.dm_be, exp_be(f3, a));
    dm_if.dm_ack   = 1'b1;
    dm_if.dm_rdata = rdt;
    #1;
    chk("ack_stall", stall, 0);
    chk("stall_cycles", ns, dly + 1);
    @(posedge clk); #1;
    dm_if.dm_ack = 1'b0;
    idle_inputs();
    chk("wb_valid", wb_valid, 1);
    chk("wb_rw", wb_reg_write, ld);
    chk("wb_rd", wb_rd, rdi);
    chk("wb_alu", wb_alu_result, a);
    if (ld) chk("wb_data", wb_mem_data, exp_load(f3, a, rdt));
    chk("req_done", dm_if.dm_req, 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          ld;
    logic [2:0]  ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1;
    idle_inputs();
    alu_result = '0; rs2_data = '0; rd = '0; funct3 = '0;
    dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
    #12;
    chk("rst_req", dm_if.dm_req, 0);
    chk("rst_be", dm_if.dm_be, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_mis", misalign_exc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU op
    in_valid = 1'b1; alu_result = 32'h1234; rd = 5'd5; reg_write = 1'b1;
    #1;
    chk("alu_stall", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("alu_wbv", wb_valid, 1);
    chk("alu_res", wb_alu_result, 32'h1234);
    chk("alu_rd", wb_rd, 5);
    chk("alu_rw", wb_reg_write, 1);
    chk("alu_mdata", wb_mem_data, 0);
    @(posedge clk); #1;
    chk("alu_wbv_drop", wb_valid, 0);

    // ack in IDLE is ignored
    dm_if.dm_ack = 1'b1;
    @(posedge clk); #1;
    dm_if.dm_ack = 1'b0;
    chk("idle_ack_wbv", wb_valid, 0);
    chk("idle_ack_req", dm_if.dm_req, 0);

    xact(1, 3'b000, 32'h103, 0, 32'h80FF_FFFF, 3, 5'd7);
    xact(1, 3'b101, 32'h102, 0, 32'hBEEF_0000, 0, 5'd8);
    xact(0, 3'b000, 32'h201, 32'h0000_00AB, 0, 1, 5'd9);
    xact(1, 3'b111, 32'h300, 0, 32'hCAFE_F00D, 2, 5'd10);

    // timeout
    in_valid = 1'b1; alu_result = 32'h400; rd = 5'd3; reg_write = 1'b1;
    mem_read = 1'b1; mem_reg = 1'b1; funct3 = 3'b010;
    @(posedge clk); #1;
    for (int k = 1; k <= 15; k++) begin
      chk("to_err_low", bus_err, 0);
      chk("to_stall", stall, k < 15);
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("to_err", bus_err, 1);
    chk("to_wbv", wb_valid, 1);
    chk("to_rw", wb_reg_write, 0);
    chk("to_req", dm_if.dm_req, 0);
    @(posedge clk); #1;
    chk("to_err_pulse", bus_err, 0);
    chk("to_idle_req", dm_if.dm_req, 0);

`ifdef MISALIGN_EXC_EN
    in_valid = 1'b1; alu_result = 32'h102; rd = 5'd4; reg_write = 1'b1;
    mem_read = 1'b1; mem_reg = 1'b1; funct3 = 3'b010;
    #1;
    chk("mis_stall", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    chk("mis_req", dm_if.dm_req, 0);
    chk("mis_exc", misalign_exc, 1);
    chk("mis_wbv", wb_valid, 1);
    chk("mis_rw", wb_reg_write, 0);
    @(posedge clk); #1;
    chk("mis_pulse", misalign_exc, 0);
`else
    xact(1, 3'b010, 32'h102, 0, 32'h1122_3344, 1, 5'd4);
    chk("mis_off", misalign_exc, 0);
`endif

    // reset while waiting
    in_valid = 1'b1; alu_result = 32'h500; rd = 5'd6; reg_write = 1'b1;
    mem_read = 1'b1; mem_reg = 1'b1; funct3 = 3'b000;
    @(posedge clk); #1;
    chk("rw_req", dm_if.dm_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_req0", dm_if.dm_req, 0);
    chk("rw_be0", dm_if.dm_be, 0);
    chk("rw_stall0", stall, 0);
    chk("rw_wbv0", wb_valid, 0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rw_no_wb", wb_valid, 0);
    chk("rw_idle", dm_if.dm_req, 0);

    // randomized aligned traffic
    for (int n = 0; n < 24; n++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a  = $urandom;
      if (f3 % 4 == 1) a = a & 32'hFFFF_FFFE;
      else if (f3 % 4 != 0) a = a & 32'hFFFF_FFFC;
      xact(ld, f3, a, $urandom, $urandom,
           int'($urandom_range(0, 4)), 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, data-memory address width; MAX_WAIT, default 15, wait cycles before timeout (0 = timeout disabled); RD_W, default 5, destination-register index width.
REQ-002 The unit SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  EX/MEM slot holds an instruction
- alu_result  in  32  effective address / ALU value
- rs2_data  in  32  store data
- rd  in  RD_W  destination register
- reg_write, mem_read, mem_write, mem_reg  in  1 each  control bits from EX
- funct3  in  3  load/store size and sign
- stall  out  1  hold EX/MEM and earlier stages
- dm_req, dm_we  out  1  memory request, write enable
- dm_addr  out  ADDR_W  word-aligned address
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-shifted store data
- dm_rdata  in  32  read word
- dm_ack  in  1  memory completes current request
- wb_valid, wb_reg_write, wb_mem_reg  out  1  MEM/WB register
- wb_mem_data, wb_alu_result  out  32  MEM/WB register
- wb_rd  out  RD_W  MEM/WB register
- bus_err, misalign_exc  out  1  one-cycle fault pulses

Function
REQ-004 FSM states SHALL be IDLE and WAIT only.
REQ-005 In IDLE, an in_valid instruction with neither mem_read nor mem_write SHALL load the MEM/WB register at the next edge (1-cycle latency) with wb_mem_data=0, stall=0.
REQ-006 In IDLE, an in_valid load/store SHALL assert stall combinationally, latch address/data/control at the edge and enter WAIT.
REQ-007 In WAIT, dm_req SHALL be 1 from a register, with dm_addr, dm_we, dm_be, dm_wdata stable until dm_ack.
REQ-008 dm_ack=1 in WAIT SHALL load the MEM/WB register, including formatted load data, return to IDLE, and drop stall in that same cycle; dm_ack in IDLE SHALL be ignored.
REQ-009 Byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<(addr[1]*2); SW 1111; loads use the same masks.
REQ-010 Load formatting SHALL be: LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW pass-through; undefined funct3 SHALL act as LW.
REQ-011 dm_wdata SHALL replicate the store byte/half across lanes.
REQ-012 If MAX_WAIT>0 and MAX_WAIT cycles elapse in WAIT without dm_ack, the unit SHALL pulse bus_err, write MEM/WB with wb_reg_write=0 and wb_valid=1, and return to IDLE.
REQ-013 wb_valid SHALL be 0 on any edge where no instruction completes, including every WAIT cycle without ack.
REQ-014 A store SHALL always produce wb_reg_write=0.

Reset
REQ-015 On rst, the state SHALL become IDLE, the wait counter 0, and dm_req, dm_we, stall, all wb_* outputs, bus_err, misalign_exc and dm_be SHALL be 0, independent of clk.
REQ-016 Reset asserted in WAIT SHALL abandon the request without a WB write.

Configuration
REQ-017 With MISALIGN_EXC_EN defined, LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 SHALL issue no request, pulse misalign_exc, and complete in 1 cycle with wb_reg_write=0.
REQ-018 Without MISALIGN_EXC_EN, misalign_exc SHALL be tied 0, and misaligned accesses SHALL proceed with low address bits ignored for lane selection above the access size.

Structure
REQ-019 funct3 encodings (LB..LHU, SB..SW), the state enumeration and the byte-enable widths SHALL live in the shared package mem_pkg.
REQ-020 Lane select and extension SHALL be one combinational sub-module, load_formatter.

Verification
REQ-021 Bench scenarios SHALL be:
- ALU op (alu_result=0x1234, rd=5, reg_write=1) -> next edge wb_valid=1, wb_alu_result=0x1234, stall never high.
- LB at 0x103, ack after 3 cycles with dm_rdata=0x80FFFFFF -> dm_be=1000, stall 4 cycles, wb_mem_data=0xFFFFFF80.
- LHU at 0x102, immediate ack with rdata=0xBEEF0000 -> dm_be=1100, wb_mem_data=0x0000BEEF.
- SB rs2=0x000000AB at 0x201 -> dm_we=1, dm_be=0010, dm_wdata=0xABABABAB, wb_reg_write=0.
- Load with no ack for 15 cycles -> bus_err pulse at cycle 15, wb_reg_write=0, state IDLE.
- MISALIGN_EXC_EN, LW at 0x102 -> dm_req stays 0, misalign_exc=1 for one cycle; rst mid-WAIT -> all outputs 0 immediately.
